mem_port_arbiter: RTL and testbench

- Shares the single unified memory port of the pipelined TSC CPU between two requesters: instruction fetch (IF stage) and data access (MEM stage, LWD/SWD).
- Data requests have priority by default. A starvation counter forces a fetch grant after a bounded run of data grants.
- Produces per-requester stall signals for the hazard/pipeline-control logic.
- Uses a variable-latency ack handshake toward memory, with a timeout error flag.

---
 rtl/tsc_mem_pkg.sv | 21 ++
 rtl/fetch_starve_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsc_mem_pkg.sv
// Shared types and defaults for the TSC unified memory port arbiter.
package tsc_mem_pkg;

    localparam int DEFAULT_WORD_W = 16;
    localparam int DEFAULT_ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_I,
        ISSUE_D,
        RESP_I,
        RESP_D
    } state_t;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'd0;
    localparam gnt_t GNT_I    = 2'd1;
    localparam gnt_t GNT_D    = 2'd2;

endpackage

// File: rtl/fetch_starve_counter.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module fetch_starve_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count < limit)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count >= limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between instruction fetch and data access,
// data first with a bounded fetch-starvation run, plus an ack timeout.
module mem_port_arbiter
    import tsc_mem_pkg::*;
#(
    parameter int WORD_W           = DEFAULT_WORD_W,
    parameter int ADDR_W           = DEFAULT_ADDR_W,
    parameter int FETCH_STARVE_MAX = 3,
    parameter int ACK_TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [WORD_W-1:0] if_data,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    localparam int SC_W = (FETCH_STARVE_MAX < 1) ? 1 : $clog2(FETCH_STARVE_MAX + 1);
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [SC_W-1:0] STARVE_LIMIT = SC_W'(FETCH_STARVE_MAX);
    // Last counted cycle: abort fires on the ACK_TIMEOUT-th ISSUE cycle without ack.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    state_t          state;
    gnt_t            gnt;
    logic [TO_W-1:0] timeout_cnt;
    logic            starve_at_limit;
    logic            starve_inc;
    logic            starve_clr;

    always_comb begin
        gnt = GNT_NONE;
        if (d_req && (!if_req || !starve_at_limit)) begin
            gnt = GNT_D;
        end else if (if_req) begin
            gnt = GNT_I;
        end
    end

    assign starve_inc = (state == IDLE) && (gnt == GNT_D) && if_req;
    assign starve_clr = (state == IDLE) && (((gnt == GNT_D) && !if_req) || (gnt == GNT_I));

    fetch_starve_counter #(
        .CNT_W (SC_W)
    ) u_starve (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .limit    (STARVE_LIMIT),
        .at_limit (starve_at_limit)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_ready    <= 1'b0;
            d_ready     <= 1'b0;
            if_data     <= '0;
            d_rdata     <= '0;
            err         <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout_cnt <= '0;
                    if (gnt == GNT_D) begin
                        state     <= ISSUE_D;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_write <= d_we;
                        mem_read  <= !d_we;
                    end else if (gnt == GNT_I) begin
                        state     <= ISSUE_I;
                        mem_addr  <= if_addr;
                        mem_read  <= 1'b1;
                        mem_write <= 1'b0;
                    end
                end
                ISSUE_I, ISSUE_D: begin
                    if (mem_ack || (timeout_cnt == TO_LAST)) begin
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        timeout_cnt <= '0;
                        if (!mem_ack) begin
                            err <= 1'b1;
                        end
                        if (state == ISSUE_I) begin
                            state    <= RESP_I;
                            if_ready <= 1'b1;
                            if (mem_ack) begin
                                if_data <= mem_rdata;
                            end
                        end else begin
                            state   <= RESP_D;
                            d_ready <= 1'b1;
                            if (mem_ack && !mem_write) begin
                                d_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                RESP_I, RESP_D: begin
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign if_stall = if_req && !if_ready;
    assign d_stall  = d_req && !d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level memory/arbitration model.
module tb_mem_port_arbiter;

    localparam int WW     = 16;
    localparam int AW     = 16;
    localparam int STARVE = 3;
    localparam int TMO    = 15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          if_req, d_req, d_we, mem_ack;
    logic [AW-1:0] if_addr, d_addr, mem_addr;
    logic [WW-1:0] d_wdata, mem_rdata, if_data, d_rdata, mem_wdata;
    logic          if_ready, if_stall, d_ready, d_stall, mem_read, mem_write, err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .WORD_W           (WW),
        .ADDR_W           (AW),
        .FETCH_STARVE_MAX (STARVE),
        .ACK_TIMEOUT      (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_data   (if_data),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err)
    );

    typedef struct {
        logic          ireq;
        logic [AW-1:0] iaddr;
        logic          dreq;
        logic          dwe;
        logic [AW-1:0] daddr;
        logic [WW-1:0] dwdata;
        int unsigned   delay;
        logic [WW-1:0] rdata;
        logic          exp_d;
        logic [AW-1:0] exp_addr;
        logic          exp_rd;
        logic          exp_wr;
        logic [WW-1:0] exp_if;
        logic [WW-1:0] exp_dr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit chk);
        reset_n = 1'b0;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        step();
        step();
        if (chk) begin
            check("reset_ctrl", {mem_read, mem_write, if_ready, d_ready, err}, 0);
            check("reset_bus", {mem_addr, mem_wdata}, 0);
            check("reset_data", {if_data, d_rdata}, 0);
        end
        reset_n = 1'b1;
    endtask

    // One complete transaction from IDLE: ack after v.delay command cycles.
    task automatic run_vec(input vec_t v, input int idx);
        if_req = v.ireq; if_addr = v.iaddr;
        d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwdata;
        step();
        check($sformatf("v%0d_addr", idx), mem_addr, v.exp_addr);
        check($sformatf("v%0d_cmd", idx), {mem_read, mem_write}, {v.exp_rd, v.exp_wr});
        if (v.exp_wr) check($sformatf("v%0d_wdata", idx), mem_wdata, v.dwdata);
        check($sformatf("v%0d_stall", idx), {if_stall, d_stall}, {v.ireq, v.dreq});
        repeat (v.delay) begin
            step();
            check($sformatf("v%0d_held", idx), {mem_read, mem_write, mem_addr}, {v.exp_rd, v.exp_wr, v.exp_addr});
        end
        mem_ack = 1'b1; mem_rdata = v.rdata;
        step();
        mem_ack = 1'b0; mem_rdata = 16'($urandom);
        check($sformatf("v%0d_ready", idx), {if_ready, d_ready, mem_read, mem_write}, {!v.exp_d, v.exp_d, 2'b00});
        check($sformatf("v%0d_if_data", idx), if_data, v.exp_if);
        check($sformatf("v%0d_d_rdata", idx), d_rdata, v.exp_dr);
        if (v.exp_d) check($sformatf("v%0d_d_stall_rdy", idx), d_stall, 0);
        else check($sformatf("v%0d_if_stall_rdy", idx), if_stall, 0);
        if_req = 1'b0; d_req = 1'b0;
        step();
        check($sformatf("v%0d_pulse", idx), {if_ready, d_ready}, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[7];
        vec_t          tv;
        logic [7:0]    pat;
        int            n;
        logic [WW-1:0] mem_model[512];
        logic [1:0]    exp_rdy;
        logic [WW-1:0] exp_ifd, exp_dr, cur_wdata;
        logic [AW-1:0] cur_addr;
        logic          cmd, cmd_prev, cur_d, cur_we, exp_d;
        int            run, txns, ack_wait;

        vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 2, 16'h6A05, 1'b0, 16'h0010, 1'b1, 1'b0, 16'h6A05, 16'h0000};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 0, 16'h1234, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h6A05, 16'h0000};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0041, 16'h0000, 1, 16'h5A5A, 1'b1, 16'h0041, 1'b1, 1'b0, 16'h6A05, 16'h5A5A};
        vecs[3] = '{1'b1, 16'h0020, 1'b1, 1'b0, 16'h0050, 16'h0000, 0, 16'hC3C3, 1'b1, 16'h0050, 1'b1, 1'b0, 16'h6A05, 16'hC3C3};
        vecs[4] = '{1'b1, 16'h0022, 1'b0, 1'b0, 16'h0000, 16'h0000, 3, 16'h1111, 1'b0, 16'h0022, 1'b1, 1'b0, 16'h1111, 16'hC3C3};
        vecs[5] = '{1'b1, 16'h0030, 1'b1, 1'b1, 16'h0060, 16'h7777, 0, 16'h2222, 1'b1, 16'h0060, 1'b0, 1'b1, 16'h1111, 16'hC3C3};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0061, 16'h8888, 1, 16'h3333, 1'b1, 16'h0061, 1'b0, 1'b1, 16'h1111, 16'hC3C3};

        do_reset(1'b1);
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Contention: both requesters held, immediate acks.
        do_reset(1'b0);
        pat = 8'b1000_1000;
        if_req = 1'b1; if_addr = 16'h0100; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        for (int g = 0; g < 8; g++) begin
            step();
            check($sformatf("cont_grant%0d", g), mem_addr, pat[g] ? 16'h0100 : 16'h0200);
            check($sformatf("cont_if_stall%0d", g), if_stall, 1);
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            check($sformatf("cont_ready%0d", g), {if_ready, d_ready}, pat[g] ? 2'b10 : 2'b01);
            check($sformatf("cont_if_stall_rdy%0d", g), if_stall, !pat[g]);
            step();
        end
        if_req = 1'b0; d_req = 1'b0;

        // Timeout on a data read that never gets acked.
        do_reset(1'b0);
        tv = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0070, 16'h0000, 0, 16'hABCD, 1'b1, 16'h0070, 1'b1, 1'b0, 16'h0000, 16'hABCD};
        run_vec(tv, 7);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0072;
        step();
        n = 0;
        for (int i = 0; i < 40 && mem_read; i++) begin
            n++;
            step();
        end
        check("tmo_cycles", n, TMO);
        check("tmo_err_ready", {err, d_ready, mem_read}, 3'b110);
        check("tmo_d_rdata", d_rdata, 16'hABCD);
        d_req = 1'b0;
        step();
        check("tmo_ready_once", d_ready, 0);
        repeat (5) step();
        check("tmo_err_sticky", err, 1);

        // Reset in the middle of a fetch, stale ack afterwards.
        if_req = 1'b1; if_addr = 16'h0044;
        step();
        check("rst_cmd_before", {mem_read, mem_addr}, {1'b1, 16'h0044});
        reset_n = 1'b0;
        step();
        reset_n = 1'b1; if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        check("rst_outputs", {mem_read, mem_write, if_ready, d_ready, err}, 0);
        check("rst_data", {if_data, d_rdata}, 0);
        step();
        mem_ack = 1'b0;
        check("rst_stale_ack", {if_ready, d_ready, mem_read, err}, 0);
        check("rst_stale_data", if_data, 0);
        step();
        check("rst_quiet", {if_ready, mem_read}, 0);

        // Acks outside an issue state.
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        step();
        mem_ack = 1'b0;
        check("idle_ack", {if_ready, d_ready, mem_read, mem_write}, 0);
        check("idle_ack_data", {if_data, d_rdata}, 0);
        if_req = 1'b1; if_addr = 16'h0080;
        step();
        mem_ack = 1'b1; mem_rdata = 16'h4242;
        step();
        check("resp_if_data", {if_ready, if_data}, {1'b1, 16'h4242});
        if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h7777;
        step();
        mem_ack = 1'b0;
        check("resp_ack_ignored", {if_ready, mem_read, if_data}, {1'b0, 1'b0, 16'h4242});
        step();
        check("resp_ack_idle", {mem_read, if_ready, d_ready}, 0);

        // Randomized traffic against a memory + arbitration-rule model.
        do_reset(1'b0);
        for (int i = 0; i < 512; i++) mem_model[i] = 16'($urandom);
        cmd_prev = 1'b0; exp_rdy = 2'b00; exp_ifd = '0; exp_dr = '0;
        run = 0; txns = 0; ack_wait = 0;
        cur_d = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_wdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            check("rnd_ready", {if_ready, d_ready}, exp_rdy);
            if (exp_rdy[1]) check("rnd_if_data", if_data, exp_ifd);
            if (exp_rdy[0]) check("rnd_d_rdata", d_rdata, exp_dr);
            check("rnd_stall", {if_stall, d_stall}, {if_req && !if_ready, d_req && !d_ready});
            check("rnd_err_cmd", {err, mem_read && mem_write}, 2'b00);
            cmd = mem_read || mem_write;
            if (cmd && !cmd_prev) begin
                exp_d     = d_req && (!if_req || run < STARVE);
                cur_d     = exp_d;
                cur_we    = exp_d && d_we;
                cur_addr  = exp_d ? d_addr : if_addr;
                cur_wdata = d_wdata;
                check("rnd_grant_addr", mem_addr, cur_addr);
                check("rnd_grant_cmd", {mem_read, mem_write}, {!cur_we, cur_we});
                if (cur_we) check("rnd_wdata", mem_wdata, cur_wdata);
                if (exp_d && if_req) run = (run < STARVE) ? run + 1 : STARVE;
                else run = 0;
                ack_wait = int'($urandom_range(0, 3));
                txns++;
            end else if (cmd) begin
                check("rnd_cmd_held", mem_addr, cur_addr);
            end
            cmd_prev = cmd;

            if (if_ready) if_req = 1'b0;
            else if (!if_req && $urandom_range(0, 1) == 0) begin
                if_req = 1'b1; if_addr = {8'h00, 8'($urandom)};
            end
            if (d_ready) d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 1) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = {8'h01, 8'($urandom)}; d_wdata = 16'($urandom);
            end

            exp_rdy = 2'b00; mem_ack = 1'b0; mem_rdata = 16'($urandom);
            if (cmd) begin
                if (ack_wait == 0) begin
                    mem_ack = 1'b1;
                    if (cur_we) mem_model[cur_addr[8:0]] = cur_wdata;
                    else begin
                        mem_rdata = mem_model[cur_addr[8:0]];
                        if (cur_d) exp_dr = mem_rdata;
                        else exp_ifd = mem_rdata;
                    end
                    exp_rdy = cur_d ? 2'b01 : 2'b10;
                end else begin
                    ack_wait--;
                end
            end else begin
                mem_ack = ($urandom_range(0, 7) == 0);
            end
        end
        check("rnd_txn_count", txns > 150, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
